// File: rtl/fp_wb_scheduler.sv
// FP writeback scheduler: register scoreboard with issue hazard stall and a
// round-robin arbiter that merges FPU and FP-load results onto one write port.
module fp_wb_scheduler #(
    parameter int FLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            issue_valid_i,
    input  logic [4:0]      issue_frd_i,
    input  logic [4:0]      issue_frs1_i,
    input  logic [4:0]      issue_frs2_i,
    input  logic [4:0]      issue_frs3_i,
    input  logic [2:0]      issue_use_i,
    output logic            issue_stall_o,
    input  logic            fpu_valid_i,
    input  logic [4:0]      fpu_rd_i,
    input  logic [FLEN-1:0] fpu_data_i,
    output logic            fpu_ready_o,
    input  logic            lsu_valid_i,
    input  logic [4:0]      lsu_rd_i,
    input  logic [FLEN-1:0] lsu_data_i,
    output logic            lsu_ready_o,
    output logic            fregwrite_o,
    output logic [4:0]      frd_o,
    output logic [FLEN-1:0] writeback_data_o,
    output logic [NREG-1:0] busy_o,
    output logic            wb_err_o
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            ptr_q, ptr_d;
    logic            fregwrite_q;
    logic [4:0]      frd_q, frd_d;
    logic [FLEN-1:0] wdata_q, wdata_d;
    logic            wb_err_q, wb_err_d;

    logic            src_haz, waw_haz, issue_acc;
    logic            fpu_gnt, lsu_gnt, gnt_any;
    logic [4:0]      gnt_rd;
    logic [FLEN-1:0] gnt_data;

    // Hazards look only at the registered scoreboard: a same-cycle clear is
    // deliberately not forwarded to the issue stage.
    always_comb begin
        src_haz   = (issue_use_i[0] & busy_q[issue_frs1_i])
                  | (issue_use_i[1] & busy_q[issue_frs2_i])
                  | (issue_use_i[2] & busy_q[issue_frs3_i]);
        waw_haz   = busy_q[issue_frd_i];
        issue_acc = issue_valid_i & ~(src_haz | waw_haz);
    end

    // ptr_q names the last winner; on a tie the other requester is granted.
    always_comb begin
        fpu_gnt  = fpu_valid_i & (~lsu_valid_i | ptr_q);
        lsu_gnt  = lsu_valid_i & (~fpu_valid_i | ~ptr_q);
        gnt_any  = fpu_gnt | lsu_gnt;
        gnt_rd   = lsu_gnt ? lsu_rd_i : fpu_rd_i;
        gnt_data = lsu_gnt ? lsu_data_i : fpu_data_i;
    end

    always_comb begin
        busy_d = busy_q;
        if (gnt_any) begin
            busy_d[gnt_rd] = 1'b0;
        end
        // The set is applied last so it wins if both ever hit the same bit.
        if (issue_acc) begin
            busy_d[issue_frd_i] = 1'b1;
        end
        ptr_d    = gnt_any ? lsu_gnt : ptr_q;
        frd_d    = gnt_any ? gnt_rd : frd_q;
        wdata_d  = gnt_any ? gnt_data : wdata_q;
        wb_err_d = wb_err_q | (gnt_any & ~busy_q[gnt_rd]);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q      <= '0;
            ptr_q       <= 1'b1;
            fregwrite_q <= 1'b0;
            frd_q       <= '0;
            wdata_q     <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
            fregwrite_q <= gnt_any;
            frd_q       <= frd_d;
            wdata_q     <= wdata_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign issue_stall_o    = issue_valid_i & (src_haz | waw_haz);
    assign fpu_ready_o      = fpu_gnt;
    assign lsu_ready_o      = lsu_gnt;
    assign fregwrite_o      = fregwrite_q;
    assign frd_o            = frd_q;
    assign writeback_data_o = wdata_q;
    assign busy_o           = busy_q;
    assign wb_err_o         = wb_err_q;

endmodule

// File: tb/tb_fp_wb_scheduler.sv
// Bench for fp_wb_scheduler: directed scenarios followed by random traffic,
// all checked against a scoreboard/arbiter reference model.
module tb_fp_wb_scheduler;

    localparam int FLEN = 32;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            issue_valid_i;
    logic [4:0]      issue_frd_i, issue_frs1_i, issue_frs2_i, issue_frs3_i;
    logic [2:0]      issue_use_i;
    logic            issue_stall_o;
    logic            fpu_valid_i;
    logic [4:0]      fpu_rd_i;
    logic [FLEN-1:0] fpu_data_i;
    logic            fpu_ready_o;
    logic            lsu_valid_i;
    logic [4:0]      lsu_rd_i;
    logic [FLEN-1:0] lsu_data_i;
    logic            lsu_ready_o;
    logic            fregwrite_o;
    logic [4:0]      frd_o;
    logic [FLEN-1:0] writeback_data_o;
    logic [NREG-1:0] busy_o;
    logic            wb_err_o;

    fp_wb_scheduler #(.FLEN(FLEN), .NREG(NREG)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_frd_i(issue_frd_i),
        .issue_frs1_i(issue_frs1_i), .issue_frs2_i(issue_frs2_i),
        .issue_frs3_i(issue_frs3_i), .issue_use_i(issue_use_i),
        .issue_stall_o(issue_stall_o),
        .fpu_valid_i(fpu_valid_i), .fpu_rd_i(fpu_rd_i),
        .fpu_data_i(fpu_data_i), .fpu_ready_o(fpu_ready_o),
        .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i),
        .lsu_data_i(lsu_data_i), .lsu_ready_o(lsu_ready_o),
        .fregwrite_o(fregwrite_o), .frd_o(frd_o),
        .writeback_data_o(writeback_data_o),
        .busy_o(busy_o), .wb_err_o(wb_err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the set of registers awaiting a result, who won last,
    // and the most recent write-port contents.
    bit        m_busy[NREG];
    int        m_last;          // 0 = FPU won last, 1 = LSU won last
    bit        m_we;
    logic [4:0] m_frd;
    logic [31:0] m_data;
    bit        m_err;

    bit obs_stall, obs_fr, obs_lr;
    bit exp_fg, exp_lg;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic idle_inputs();
        issue_valid_i = 0; issue_frd_i = 0; issue_frs1_i = 0;
        issue_frs2_i = 0; issue_frs3_i = 0; issue_use_i = 0;
        fpu_valid_i = 0; fpu_rd_i = 0; fpu_data_i = 0;
        lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
    endtask

    // One clock: inputs are already applied; check combinational outputs,
    // advance the model at the edge, then check registered outputs.
    task automatic cycle();
        bit src, waw, stall, gr, acc;
        logic [4:0] grd;
        logic [31:0] gdat;
        src = (issue_use_i[0] && m_busy[issue_frs1_i]) ||
              (issue_use_i[1] && m_busy[issue_frs2_i]) ||
              (issue_use_i[2] && m_busy[issue_frs3_i]);
        waw = m_busy[issue_frd_i];
        stall = issue_valid_i && (src || waw);
        acc = issue_valid_i && !stall;
        if (fpu_valid_i && lsu_valid_i) begin
            exp_fg = (m_last == 1);
            exp_lg = !exp_fg;
        end else begin
            exp_fg = fpu_valid_i;
            exp_lg = lsu_valid_i;
        end
        gr   = exp_fg || exp_lg;
        grd  = exp_fg ? fpu_rd_i : lsu_rd_i;
        gdat = exp_fg ? fpu_data_i : lsu_data_i;
        #1;
        obs_stall = issue_stall_o; obs_fr = fpu_ready_o; obs_lr = lsu_ready_o;
        chk("stall", issue_stall_o, stall);
        chk("fpu_ready", fpu_ready_o, exp_fg);
        chk("lsu_ready", lsu_ready_o, exp_lg);
        @(posedge clk);
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 0;
            m_last = 1; m_we = 0; m_frd = 0; m_data = 0; m_err = 0;
        end else begin
            if (gr) begin
                if (!m_busy[grd]) m_err = 1;
                m_busy[grd] = 0;
                m_frd = grd; m_data = gdat;
                m_last = exp_lg ? 1 : 0;
            end
            m_we = gr;
            if (acc) m_busy[issue_frd_i] = 1;
        end
        @(negedge clk);
        chk("busy", busy_o, model_busy_vec());
        chk("fregwrite", fregwrite_o, m_we);
        chk("frd", frd_o, m_frd);
        chk("wdata", writeback_data_o, m_data);
        chk("wb_err", wb_err_o, m_err);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 0;
        cycle();
        rst_ni = 1;
    endtask

    bit fp_pend, ls_pend;
    logic [4:0] fp_rd, ls_rd;
    logic [31:0] fp_dat, ls_dat;

    initial begin
        idle_inputs();
        rst_ni = 0;
        for (int i = 0; i < NREG; i++) m_busy[i] = 0;
        m_last = 1; m_we = 0; m_frd = 0; m_data = 0; m_err = 0;
        @(negedge clk);
        do_reset();
        chk("reset_busy", busy_o, 32'h0);
        chk("reset_fregwrite", fregwrite_o, 1'b0);
        chk("reset_err", wb_err_o, 1'b0);

        // RAW: source stalls while busy, released by the writeback
        issue_valid_i = 1; issue_frd_i = 5; cycle();
        issue_frd_i = 6; issue_frs1_i = 5; issue_use_i = 3'b001;
        fpu_valid_i = 1; fpu_rd_i = 5; fpu_data_i = 32'h4049_0FDB;
        cycle();
        chk("raw_stall_grant_cycle", obs_stall, 1'b1);
        chk("raw_fregwrite", fregwrite_o, 1'b1);
        chk("raw_frd", frd_o, 5'd5);
        fpu_valid_i = 0; cycle();
        issue_valid_i = 0; cycle();
        chk("raw_fregwrite_drop", fregwrite_o, 1'b0);

        // WAW on register 3
        issue_valid_i = 1; issue_frd_i = 3; issue_use_i = 0; cycle();
        fpu_valid_i = 1; fpu_rd_i = 3; fpu_data_i = 32'h1111_2222;
        cycle();
        chk("waw_stall", obs_stall, 1'b1);
        fpu_valid_i = 0; cycle();
        chk("waw_accept", obs_stall, 1'b0);
        chk("waw_reset_busy3", busy_o[3], 1'b1);
        issue_valid_i = 0;
        lsu_valid_i = 1; lsu_rd_i = 3; lsu_data_i = 32'h5; cycle();
        lsu_valid_i = 0;
        lsu_valid_i = 1; lsu_rd_i = 6; lsu_data_i = 32'h6; cycle();
        lsu_valid_i = 0;

        // Issue and grant in the same cycle
        issue_valid_i = 1; issue_frd_i = 9; cycle();
        issue_frd_i = 2;
        fpu_valid_i = 1; fpu_rd_i = 9; fpu_data_i = 32'hCAFE_0009;
        cycle();
        chk("same_cycle_busy2", busy_o[2], 1'b1);
        chk("same_cycle_busy9", busy_o[9], 1'b0);
        chk("same_cycle_frd", frd_o, 5'd9);
        idle_inputs();
        fpu_valid_i = 1; fpu_rd_i = 2; fpu_data_i = 32'h2; cycle();
        idle_inputs();

        // Writeback to a non-busy register flags a sticky error
        chk("err_before", wb_err_o, 1'b0);
        lsu_valid_i = 1; lsu_rd_i = 7; lsu_data_i = 32'h3F80_0000; cycle();
        chk("err_frd", frd_o, 5'd7);
        chk("err_data", writeback_data_o, 32'h3F80_0000);
        chk("err_set", wb_err_o, 1'b1);
        idle_inputs(); cycle(); cycle();
        chk("err_sticky", wb_err_o, 1'b1);

        // Reset mid-operation with busy = 0x110 and a grant pending
        issue_valid_i = 1; issue_frd_i = 4; cycle();
        issue_frd_i = 8; cycle();
        issue_valid_i = 0;
        chk("pre_reset_busy", busy_o, 32'h0000_0110);
        fpu_valid_i = 1; fpu_rd_i = 4; fpu_data_i = 32'hDEAD_BEEF;
        rst_ni = 0; cycle(); rst_ni = 1;
        chk("mid_reset_busy", busy_o, 32'h0);
        chk("mid_reset_fregwrite", fregwrite_o, 1'b0);
        chk("mid_reset_err", wb_err_o, 1'b0);
        idle_inputs(); cycle();
        chk("post_reset_no_pulse", fregwrite_o, 1'b0);

        // Round-robin: both valid for four cycles right after reset
        do_reset();
        fpu_valid_i = 1; lsu_valid_i = 1;
        for (int k = 0; k < 4; k++) begin
            fpu_rd_i = 5'(10 + k); lsu_rd_i = 5'(20 + k);
            fpu_data_i = 32'(k); lsu_data_i = 32'(100 + k);
            cycle();
            chk("rr_fpu", obs_fr, (k % 2 == 0));
            chk("rr_lsu", obs_lr, (k % 2 == 1));
        end
        idle_inputs();

        // Random traffic with requesters that hold until ready
        do_reset();
        fp_pend = 0; ls_pend = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!fp_pend && $urandom_range(0, 2) == 0) begin
                fp_pend = 1; fp_rd = 5'($urandom_range(0, 7)); fp_dat = $urandom;
            end
            if (!ls_pend && $urandom_range(0, 2) == 0) begin
                ls_pend = 1; ls_rd = 5'($urandom_range(0, 7)); ls_dat = $urandom;
            end
            fpu_valid_i = fp_pend; fpu_rd_i = fp_rd; fpu_data_i = fp_dat;
            lsu_valid_i = ls_pend; lsu_rd_i = ls_rd; lsu_data_i = ls_dat;
            issue_valid_i = 1'($urandom_range(0, 1));
            issue_frd_i  = 5'($urandom_range(0, 7));
            issue_frs1_i = 5'($urandom_range(0, 7));
            issue_frs2_i = 5'($urandom_range(0, 7));
            issue_frs3_i = 5'($urandom_range(0, 7));
            issue_use_i  = 3'($urandom_range(0, 7));
            rst_ni = ($urandom_range(0, 299) != 0);
            cycle();
            if (exp_fg) fp_pend = 0;
            if (exp_lg) ls_pend = 0;
        end
        rst_ni = 1;
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
